// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Brief    : Shared NoC router types: port indices, flit layout, requester FSM.
// Revision : 1.0
// ============================================================================
package noc_pkg;

   localparam int NPORTS = 5;
   localparam int P_L    = 0;
   localparam int P_E    = 1;
   localparam int P_W    = 2;
   localparam int P_N    = 3;
   localparam int P_S    = 4;

   typedef logic [NPORTS-1:0] port_vec_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2,
      ST_REL  = 2'd3
   } req_state_t;

   // Flit = {head, tail, payload[DATA_W-1:0]}
   function automatic int flit_w(input int data_w);
      return data_w + 2;
   endfunction

   function automatic int head_bit(input int data_w);
      return data_w + 1;
   endfunction

   function automatic int tail_bit(input int data_w);
      return data_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/port_requester_if.sv
`default_nettype none
// ============================================================================
// Module   : port_requester_if
// Brief    : Buffer / arbiter / crossbar signals seen by one router input port.
// Revision : 1.0
// ============================================================================
interface port_requester_if
   import noc_pkg::*;
#(
   parameter int DATA_W = 32
);
   localparam int FLIT_W = flit_w(DATA_W);

   logic              buf_empty;
   logic [FLIT_W-1:0] buf_flit;
   logic              buf_rd;
   port_vec_t         gnt;
   port_vec_t         dn_full;
   port_vec_t         req;
   logic [FLIT_W-1:0] flit_out;
   logic              flit_vld;
   port_vec_t         port_sel;
   logic              err;

   modport master (
      input  buf_empty, buf_flit, gnt, dn_full,
      output buf_rd, req, flit_out, flit_vld, port_sel, err
   );

   modport slave (
      output buf_empty, buf_flit, gnt, dn_full,
      input  buf_rd, req, flit_out, flit_vld, port_sel, err
   );

endinterface
`default_nettype wire

// File: rtl/xy_route.sv
`default_nettype none
// ============================================================================
// Module   : xy_route
// Brief    : Dimension-ordered (X then Y) route to a one-hot output port.
// Revision : 1.0
// ============================================================================
module xy_route
   import noc_pkg::*;
#(
   parameter int COORD_W = 2,
   parameter int CUR_X   = 0,
   parameter int CUR_Y   = 0
) (
   input  logic [COORD_W-1:0] dx,
   input  logic [COORD_W-1:0] dy,
   output port_vec_t          port_oh
);
   localparam logic [COORD_W-1:0] c_cur_x = COORD_W'(CUR_X);
   localparam logic [COORD_W-1:0] c_cur_y = COORD_W'(CUR_Y);

   always_comb begin
      port_oh = '0;
      if (dx > c_cur_x)      port_oh[P_E] = 1'b1;
      else if (dx < c_cur_x) port_oh[P_W] = 1'b1;
      else if (dy > c_cur_y) port_oh[P_N] = 1'b1;
      else if (dy < c_cur_y) port_oh[P_S] = 1'b1;
      else                   port_oh[P_L] = 1'b1;
   end

endmodule
`default_nettype wire

// File: rtl/port_requester.sv
`default_nettype none
// ============================================================================
// Module   : port_requester
// Brief    : Input-port requester: routes head flit, holds one-hot req to the
//            output arbiter, forwards the packet to the crossbar.
// Revision : 1.0
// ============================================================================
module port_requester
   import noc_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int COORD_W = 2,
   parameter int CUR_X   = 0,
   parameter int CUR_Y   = 0
) (
   input  logic             clk,
   input  logic             rst,
   port_requester_if.master bus
);
   localparam int c_flit_w   = flit_w(DATA_W);
   localparam int c_head_bit = head_bit(DATA_W);
   localparam int c_tail_bit = tail_bit(DATA_W);

   req_state_t          r_state;
   req_state_t          w_state_nxt;
   port_vec_t           r_port_q;
   port_vec_t           w_route;
   port_vec_t           w_port_nxt;
   port_vec_t           r_req;
   port_vec_t           r_port_sel;
   logic [c_flit_w-1:0] r_flit_out;
   logic                r_flit_vld;
   logic                r_err;
   logic                w_pop;
   logic                w_drop;
   logic                w_head;
   logic                w_tail;

   assign w_head = bus.buf_flit[c_head_bit];
   assign w_tail = bus.buf_flit[c_tail_bit];

   xy_route #(
      .COORD_W (COORD_W),
      .CUR_X   (CUR_X),
      .CUR_Y   (CUR_Y)
   ) u_xy_route (
      .dx      (bus.buf_flit[2*COORD_W-1:COORD_W]),
      .dy      (bus.buf_flit[COORD_W-1:0]),
      .port_oh (w_route)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!bus.buf_empty) begin
               if (w_head) w_state_nxt = ST_REQ;
               else        w_drop      = 1'b1;
            end
         end
         ST_REQ: begin
            if (|(bus.gnt & r_port_q)) w_state_nxt = ST_XFER;
         end
         ST_XFER: begin
            // Head bits inside a packet are plain payload here
            w_pop = (|(bus.gnt & r_port_q)) && !(|(bus.dn_full & r_port_q))
                    && !bus.buf_empty;
            if (w_pop && w_tail) w_state_nxt = ST_REL;
         end
         ST_REL: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_port_nxt = (r_state == ST_IDLE) ? w_route : r_port_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   // req follows the next state, so it drops for the whole REL cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_port_q   <= '0;
         r_req      <= '0;
         r_flit_out <= '0;
         r_flit_vld <= 1'b0;
         r_port_sel <= '0;
         r_err      <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && w_state_nxt == ST_REQ) r_port_q <= w_route;
         r_req      <= (w_state_nxt == ST_REQ || w_state_nxt == ST_XFER) ? w_port_nxt : '0;
         r_flit_vld <= w_pop;
         r_port_sel <= w_pop ? r_port_q : '0;
         if (w_pop) r_flit_out <= bus.buf_flit;
         r_err      <= w_drop;
      end
   end

   assign bus.buf_rd   = w_pop | w_drop;
   assign bus.req      = r_req;
   assign bus.flit_out = r_flit_out;
   assign bus.flit_vld = r_flit_vld;
   assign bus.port_sel = r_port_sel;
   assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_port_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_port_requester
// Brief    : Directed bench for port_requester with FWFT buffer and registered
//            arbiter models. Router sits at (1,1).
// Revision : 1.0
// ============================================================================
module tb_port_requester;
   import noc_pkg::*;

   localparam int DATA_W  = 32;
   localparam int COORD_W = 2;
   localparam int CUR_X   = 1;
   localparam int CUR_Y   = 1;
   localparam int FLIT_W  = DATA_W + 2;

   typedef logic [FLIT_W-1:0] flit_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   port_requester_if #(.DATA_W(DATA_W)) bus ();

   port_requester #(
      .DATA_W  (DATA_W),
      .COORD_W (COORD_W),
      .CUR_X   (CUR_X),
      .CUR_Y   (CUR_Y)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   flit_t fifo[$];
   flit_t pk[$];
   logic  gnt_en;
   int    n_chk  = 0;
   int    n_fail = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic flit_t mk(input logic h, input logic t, input int x, input int y, input int tag);
      return {h, t, 24'(tag), 4'h0, 2'(x), 2'(y)};
   endfunction

   task automatic drive();
      bus.buf_empty = (fifo.size() == 0);
      bus.buf_flit  = (fifo.size() == 0) ? '0 : fifo[0];
   endtask

   task automatic push_pkt(input int x, input int y, input int n, input int tag);
      for (int i = 0; i < n; i++) begin
         pk.push_back(mk(i == 0, i == n - 1, x, y, tag + i));
         fifo.push_back(mk(i == 0, i == n - 1, x, y, tag + i));
      end
      drive();
   endtask

   // One clock: buffer pops on buf_rd, arbiter returns last cycle's req as gnt
   task automatic tick();
      logic      rd;
      port_vec_t rq;
      #1;
      rd = bus.buf_rd;
      rq = bus.req;
      @(posedge clk);
      #1;
      if (rd && fifo.size() > 0) void'(fifo.pop_front());
      bus.gnt = gnt_en ? rq : '0;
      drive();
      #1;
   endtask

   task automatic run_pkt(input string tag, input int x, input int y, input int n, input port_vec_t exp_port);
      int got  = 0;
      bit seen = 1'b0;
      bit done = 1'b0;
      pk.delete();
      push_pkt(x, y, n, 16'h600 + n);
      for (int c = 0; c < 40 && !done; c++) begin
         tick();
         if (!seen && bus.req != '0) begin
            seen = 1'b1;
            check({tag, "_req"}, bus.req, exp_port);
         end
         if (bus.flit_vld && got < n) begin
            check({tag, "_flit"}, bus.flit_out, pk[got]);
            check({tag, "_sel"}, bus.port_sel, exp_port);
            got++;
            if (got == n) done = 1'b1;
         end
      end
      check({tag, "_count"}, got, n);
      check({tag, "_rel"}, bus.req, '0);
      tick();
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      gnt_en      = 1'b1;
      bus.gnt     = '0;
      bus.dn_full = '0;
      drive();
      repeat (3) @(posedge clk);
      #2;
      check("rst_req",  bus.req,      '0);
      check("rst_vld",  bus.flit_vld, 0);
      check("rst_sel",  bus.port_sel, '0);
      check("rst_err",  bus.err,      0);
      check("rst_flit", bus.flit_out, '0);
      rst = 1'b1;
      #1;

      // 1: 3-flit packet to (2,1) -> E; middle flit carries a stray head bit
      pk.delete();
      pk.push_back(mk(1, 0, 2, 1, 24'h111));
      pk.push_back(mk(1, 0, 0, 0, 24'h112));
      pk.push_back(mk(0, 1, 0, 0, 24'h113));
      foreach (pk[i]) fifo.push_back(pk[i]);
      drive();
      #1;
      check("t1_idle_req", bus.req, '0);
      check("t1_idle_rd", bus.buf_rd, 0);
      tick();
      check("t1_req", bus.req, 5'b00010);
      tick();
      check("t1_wait_rd", bus.buf_rd, 0);
      tick();
      check("t1_xfer_rd", bus.buf_rd, 1);
      check("t1_xfer_vld", bus.flit_vld, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t1_vld", bus.flit_vld, 1);
         check("t1_flit", bus.flit_out, pk[i]);
         check("t1_sel", bus.port_sel, 5'b00010);
         if (i < 2) check("t1_req_hold", bus.req, 5'b00010);
      end
      check("t1_rel_req", bus.req, '0);
      tick();
      check("t1_idle_vld", bus.flit_vld, 0);
      check("t1_idle_req2", bus.req, '0);

      // 2: single-flit to (1,1) -> L, then a second to (1,2) -> N
      pk.delete();
      push_pkt(1, 1, 1, 24'h210);
      push_pkt(1, 2, 1, 24'h220);
      tick();
      check("t2_req", bus.req, 5'b00001);
      tick();
      tick();
      check("t2_rd", bus.buf_rd, 1);
      tick();
      check("t2_vld", bus.flit_vld, 1);
      check("t2_flit", bus.flit_out, pk[0]);
      check("t2_sel", bus.port_sel, 5'b00001);
      check("t2_rel_req", bus.req, '0);
      check("t2_rel_rd", bus.buf_rd, 0);
      tick();
      check("t2_gap_req", bus.req, '0);
      check("t2_gap_vld", bus.flit_vld, 0);
      tick();
      check("t2_req2", bus.req, 5'b01000);
      tick();
      tick();
      tick();
      check("t2_vld2", bus.flit_vld, 1);
      check("t2_flit2", bus.flit_out, pk[1]);
      check("t2_sel2", bus.port_sel, 5'b01000);
      tick();

      // 3: route to (1,0) -> S, gnt withheld 10 cycles, then 2-cycle dn_full
      pk.delete();
      push_pkt(1, 0, 4, 24'h300);
      gnt_en = 1'b0;
      tick();
      check("t3_req", bus.req, 5'b10000);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t3_hold", {bus.req, bus.buf_rd, bus.flit_vld}, {5'b10000, 1'b0, 1'b0});
      end
      gnt_en = 1'b1;
      tick();
      tick();
      check("t3_xfer_rd", bus.buf_rd, 1);
      tick();
      check("t3_flit0", bus.flit_out, pk[0]);
      bus.dn_full = 5'b10000;
      #1;
      check("t3_full_rd", bus.buf_rd, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("t3_stall", {bus.req, bus.buf_rd, bus.flit_vld}, {5'b10000, 1'b0, 1'b0});
      end
      bus.dn_full = '0;
      #1;
      check("t3_resume_rd", bus.buf_rd, 1);
      for (int i = 1; i < 4; i++) begin
         tick();
         check("t3_vld", bus.flit_vld, 1);
         check("t3_flit", bus.flit_out, pk[i]);
      end
      check("t3_rel_req", bus.req, '0);
      tick();

      // 4: body flit at the front while idle
      fifo.push_back(mk(0, 0, 2, 2, 24'h400));
      drive();
      #1;
      check("t4_rd", bus.buf_rd, 1);
      check("t4_err_pre", bus.err, 0);
      tick();
      check("t4_err", bus.err, 1);
      check("t4_req", bus.req, '0);
      check("t4_popped", fifo.size(), 0);
      tick();
      check("t4_err_end", bus.err, 0);

      // 5: asynchronous reset in the middle of a 4-flit packet
      pk.delete();
      push_pkt(2, 1, 4, 24'h500);
      repeat (5) tick();
      check("t5_pre_vld", bus.flit_vld, 1);
      check("t5_pre_flit", bus.flit_out, pk[1]);
      rst     = 1'b0;
      bus.gnt = '0;
      fifo.delete();
      drive();
      #1;
      check("t5_req", bus.req, '0);
      check("t5_vld", bus.flit_vld, 0);
      check("t5_sel", bus.port_sel, '0);
      tick();
      check("t5_held_req", bus.req, '0);
      rst = 1'b1;
      run_pkt("t5_after", 0, 1, 1, 5'b00100);

      // 6: X resolved before Y
      run_pkt("t6_w", 0, 1, 1, 5'b00100);
      run_pkt("t6_n", 1, 2, 1, 5'b01000);
      run_pkt("t6_e", 2, 2, 2, 5'b00010);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
